// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, LATENCY wait states,
// RV64 lane select/extension. Optional DMEM_ERR_EN flags misaligned/out-of-range/bad-funct3 accesses.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_stall
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        enter_resp;

    logic        l_write;
    logic [2:0]  l_funct3;
    logic [63:0] l_addr, l_wdata;

    logic        op_write;
    logic [2:0]  op_funct3;
    logic [63:0] op_addr, op_wdata;

    logic [AW-1:0] idx;
    logic [2:0]    lane_mask, lane;
    logic [7:0]    size_bmask, wr_bmask;
    logic [63:0]   rd_word, rd_shift, load_data, rsp_d, wr_data;
    logic          acc_err, wr_en;

    logic [63:0] mem [DEPTH];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
    // high only in IDLE, and rsp_valid is a single-cycle strobe with no back-pressure.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_stall = ((state == IDLE) && req_valid) || (state == WAIT);

    // In IDLE the live request is the one being accepted; later the latched copy is used.
    assign op_write  = (state == IDLE) ? req_write  : l_write;
    assign op_funct3 = (state == IDLE) ? req_funct3 : l_funct3;
    assign op_addr   = (state == IDLE) ? req_addr   : l_addr;
    assign op_wdata  = (state == IDLE) ? req_wdata  : l_wdata;

    assign idx = op_addr[3+AW-1:3];

    always_comb begin
        lane_mask  = 3'b000;
        size_bmask = 8'hFF;
        case (op_funct3[1:0])
            2'b00: begin lane_mask = 3'b111; size_bmask = 8'h01; end
            2'b01: begin lane_mask = 3'b110; size_bmask = 8'h03; end
            2'b10: begin lane_mask = 3'b100; size_bmask = 8'h0F; end
            default: begin lane_mask = 3'b000; size_bmask = 8'hFF; end
        endcase
    end

    assign lane = op_addr[2:0] & lane_mask;

`ifdef DMEM_ERR_EN
    logic misalign, oob, bad_f3;
    assign misalign = |(op_addr[2:0] & ~lane_mask);
    assign oob      = (op_addr >= 64'(DEPTH * 8));
    assign bad_f3   = op_write ? op_funct3[2] : (op_funct3 == 3'b111);
    assign acc_err  = misalign | oob | bad_f3;
`else
    logic unused_hi_addr;
    assign unused_hi_addr = ^op_addr[63:3+AW];
    assign acc_err = 1'b0;
`endif

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        load_data = 64'd0;
        case (op_funct3)
            3'b000: load_data = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'b001: load_data = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010: load_data = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011: load_data = rd_shift;
            3'b100: load_data = {56'd0, rd_shift[7:0]};
            3'b101: load_data = {48'd0, rd_shift[15:0]};
            3'b110: load_data = {32'd0, rd_shift[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    assign rsp_d    = (op_write || acc_err) ? 64'd0 : load_data;
    assign wr_data  = op_wdata << {lane, 3'b000};
    assign wr_bmask = size_bmask << lane;
    assign wr_en    = enter_resp && op_write && !op_funct3[2] && !acc_err && !rst;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
            l_write   <= 1'b0;
            l_funct3  <= 3'd0;
            l_addr    <= 64'd0;
            l_wdata   <= 64'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rsp_rdata <= enter_resp ? rsp_d : 64'd0;
            rsp_err   <= enter_resp & acc_err;
            if ((state == IDLE) && req_valid) begin
                l_write  <= req_write;
                l_funct3 <= req_funct3;
                l_addr   <= req_addr;
                l_wdata  <= req_wdata;
            end
        end
    end

    // Store commits on the edge entering RESP; memory itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_bmask[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

endmodule
